// File: rtl/control_unit_if.sv
// Opcode-in / control-word-out bundle between the decode stage and control_unit.
interface control_unit_if;
  logic [5:0] opcode;
  logic       reg_dst;
  logic       reg_write;
  logic       ext_op;
  logic       ALU_scr;
  logic       beq;
  logic       bne;
  logic       j;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_to_reg;
  logic       illegal;

  // Decode stage drives the opcode and consumes the control word.
  modport master (
    output opcode,
    input  reg_dst, reg_write, ext_op, ALU_scr, beq, bne, j,
    input  mem_read, mem_write, mem_to_reg, illegal
  );

  // Control unit consumes the opcode and drives the control word.
  modport slave (
    input  opcode,
    output reg_dst, reg_write, ext_op, ALU_scr, beq, bne, j,
    output mem_read, mem_write, mem_to_reg, illegal
  );
endinterface

// File: rtl/control_unit.sv
// MIPS32 main decoder: primary opcode -> registered datapath control word.
module control_unit (
  input  logic          clk,
  input  logic          rst,
  control_unit_if.slave bus
);

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned WB_SEL_W = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

  localparam logic [WB_SEL_W-1:0] WB_ALU = 2'b00;
  localparam logic [WB_SEL_W-1:0] WB_MEM = 2'b01;

  typedef struct packed {
    logic                reg_dst;
    logic                reg_write;
    logic                ext_op;
    logic                alu_src;
    logic                beq;
    logic                bne;
    logic                j;
    logic                mem_read;
    logic                mem_write;
    logic [WB_SEL_W-1:0] mem_to_reg;
    logic                illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  ctrl_t ctrl_c;
  ctrl_t ctrl_q;

  // Combinational decode; NOP word by default, unknown opcodes flagged illegal.
  always_comb begin
    ctrl_c            = CTRL_NOP;
    ctrl_c.mem_to_reg = WB_ALU;
    case (bus.opcode)
      OP_RTYPE: begin
        ctrl_c.reg_write = 1'b1;
      end
      OP_ADDI, OP_SLTI: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.ext_op    = 1'b1;
        ctrl_c.alu_src   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.alu_src   = 1'b1;
      end
      OP_LW: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = 1'b1;
        ctrl_c.ext_op     = 1'b1;
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.mem_to_reg = WB_MEM;
      end
      OP_SW: begin
        ctrl_c.ext_op    = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_c.beq    = 1'b1;
        ctrl_c.ext_op = 1'b1;
      end
      OP_BNE: begin
        ctrl_c.bne    = 1'b1;
        ctrl_c.ext_op = 1'b1;
      end
      OP_J: begin
        ctrl_c.j = 1'b1;
      end
      default: begin
        ctrl_c.illegal = 1'b1;
      end
    endcase
  end

  // Output register at the decode/execute boundary; reset wins over any opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= CTRL_NOP;
    end else begin
      ctrl_q <= ctrl_c;
    end
  end

  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.ext_op     = ctrl_q.ext_op;
  assign bus.ALU_scr    = ctrl_q.alu_src;
  assign bus.beq        = ctrl_q.beq;
  assign bus.bne        = ctrl_q.bne;
  assign bus.j          = ctrl_q.j;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
module tb_control_unit;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  control_unit_if bus ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: reg_dst reg_write ext_op ALU_scr beq bne j mem_read mem_write mem_to_reg[1:0] illegal
  localparam logic [11:0] W_NOP  = 12'b0000_0000_0000;
  localparam logic [11:0] W_R    = 12'b0100_0000_0000;
  localparam logic [11:0] W_IMMS = 12'b1111_0000_0000;
  localparam logic [11:0] W_IMMZ = 12'b1101_0000_0000;
  localparam logic [11:0] W_LW   = 12'b1111_0001_0010;
  localparam logic [11:0] W_SW   = 12'b0011_0000_1000;
  localparam logic [11:0] W_BEQ  = 12'b0010_1000_0000;
  localparam logic [11:0] W_BNE  = 12'b0010_0100_0000;
  localparam logic [11:0] W_J    = 12'b0000_0010_0000;
  localparam logic [11:0] W_ILL  = 12'b0000_0000_0001;

  function automatic logic [11:0] word();
    return {bus.reg_dst, bus.reg_write, bus.ext_op, bus.ALU_scr, bus.beq, bus.bne,
            bus.j, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.illegal};
  endfunction

  // Reference table written from the opcode list.
  function automatic logic [11:0] expect_word(input logic [5:0] op);
    case (op)
      6'b000000: return W_R;
      6'b001000: return W_IMMS;
      6'b001010: return W_IMMS;
      6'b001100: return W_IMMZ;
      6'b001101: return W_IMMZ;
      6'b001110: return W_IMMZ;
      6'b100011: return W_LW;
      6'b101011: return W_SW;
      6'b000100: return W_BEQ;
      6'b000101: return W_BNE;
      6'b000010: return W_J;
      default:   return W_ILL;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive opcode/rst mid-cycle, then sample just after the next rising edge.
  task automatic step(input logic [5:0] op, input logic r);
    @(negedge clk);
    bus.opcode = op;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  logic [11:0] w;
  logic [5:0]  dir_ops [11];
  logic [11:0] dir_exp [11];

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.opcode = 6'b100011;

    dir_ops = '{6'b000000, 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110,
                6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010};
    dir_exp = '{W_R, W_IMMS, W_IMMS, W_IMMZ, W_IMMZ, W_IMMZ,
                W_LW, W_SW, W_BEQ, W_BNE, W_J};

    // Reset held two cycles with lw on the opcode bus.
    step(6'b100011, 1'b1);
    chk("reset_cycle1", word(), W_NOP);
    step(6'b100011, 1'b1);
    chk("reset_cycle2", word(), W_NOP);
    step(6'b100011, 1'b0);
    chk("lw_after_reset", word(), W_LW);

    // Directed sequence, one opcode per cycle.
    for (int i = 0; i < 11; i++) begin
      step(dir_ops[i], 1'b0);
      chk($sformatf("directed_op%06b", dir_ops[i]), word(), dir_exp[i]);
    end

    // Extension and store/branch/jump spot checks.
    step(6'b001101, 1'b0);
    chk("ori_ext_alu", {10'd0, bus.ext_op, bus.ALU_scr}, 12'b01);
    step(6'b101011, 1'b0);
    chk("sw_rw_mr_mw", {9'd0, bus.reg_write, bus.mem_read, bus.mem_write}, 12'b001);
    step(6'b000010, 1'b0);
    chk("j_rw_mr_mw", {9'd0, bus.reg_write, bus.mem_read, bus.mem_write}, 12'b000);

    // Exhaustive sweep with a one-cycle reset injected at lw.
    for (int op = 0; op < 64; op++) begin
      if (op == 35) begin
        step(6'(op), 1'b1);
        chk("midreset_lw_dropped", word(), W_NOP);
      end else begin
        step(6'(op), 1'b0);
        w = word();
        chk($sformatf("sweep_op%06b", 6'(op)), w, expect_word(6'(op)));
        chk("inv_one_flow", 12'(($countones({bus.beq, bus.bne, bus.j}) <= 1) &&
                                !(bus.mem_read && bus.mem_write) &&
                                !bus.mem_to_reg[1] &&
                                !(bus.reg_write && (bus.mem_write || bus.beq || bus.bne || bus.j))),
            12'd1);
      end
    end

    // Back to reset, then confirm X-free behaviour on a final illegal opcode.
    step(6'b111111, 1'b1);
    chk("final_reset", word(), W_NOP);
    step(6'b111111, 1'b0);
    chk("final_illegal", word(), W_ILL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
